// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer sharing one full-adder cell

module serial_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   res_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_c;
    logic               accept;
    logic               last_bit;

    serial_fa u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = last_bit ? DONE : RUN;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction feeds ~b and seeds the carry with 1, giving A + ~B + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sh_a   <= a;
            sh_b   <= sub ? ~b : b;
            res_sh <= '0;
            carry  <= sub;
            cnt    <= '0;
        end else if (state == RUN) begin
            sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
            res_sh <= {fa_s, res_sh[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= {fa_s, res_sh[WIDTH-1:1]};
                cout <= fa_c;
                ovf  <= carry ^ fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [WIDTH-1:0] prev_sum = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s);
        int ux, uy, sx, sy, ures, sres;
        logic c, o;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            ures = ux - uy;
            sres = sx - sy;
            c = (ux >= uy);
        end else begin
            ures = ux + uy;
            sres = sx + sy;
            c = (ures > 255);
        end
        o = (sres > 127) || (sres < -128);
        return {o, c, 8'(ures)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH+1:0] e);
        chk({tag, "_sum"}, {8'h0, sum}, {8'h0, e[WIDTH-1:0]});
        chk({tag, "_cout"}, {15'h0, cout}, {15'h0, e[WIDTH]});
        chk({tag, "_ovf"}, {15'h0, ovf}, {15'h0, e[WIDTH+1]});
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4 * WIDTH) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, {15'h0, done}, 16'h1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s);
        logic [WIDTH+1:0] e;
        int bc, n;
        e = model(x, y, s);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        n = 0;
        while (done !== 1'b1 && n < 4 * WIDTH) begin
            if (busy === 1'b1) bc++;
            chk({tag, "_hold"}, {8'h0, sum}, {8'h0, prev_sum});
            tick();
            n++;
        end
        chk({tag, "_done"}, {15'h0, done}, 16'h1);
        chk({tag, "_busy_len"}, 16'(bc), 16'(WIDTH));
        chk({tag, "_excl"}, {15'h0, busy}, 16'h0);
        check_result(tag, e);
        prev_sum = e[WIDTH-1:0];
        tick();
        chk({tag, "_done_drop"}, {15'h0, done}, 16'h0);
    endtask

    initial begin
        logic [WIDTH+1:0] e1, e2;
        int d0, t1, t2;

        // Reset state
        tick();
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_done", {15'h0, done}, 16'h0);
        chk("rst_sum", {8'h0, sum}, 16'h0);
        chk("rst_cout", {15'h0, cout}, 16'h0);
        chk("rst_ovf", {15'h0, ovf}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", {15'h0, busy}, 16'h0);

        // Directed vectors
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0);
        chk("vec1_sum", {8'h0, sum}, 16'h008D);
        chk("vec1_flags", {14'h0, ovf, cout}, 16'h0002);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        chk("vec2_sum", {8'h0, sum}, 16'h0000);
        chk("vec2_flags", {14'h0, ovf, cout}, 16'h0001);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
        chk("vec3_sum", {8'h0, sum}, 16'h00F0);
        chk("vec3_flags", {14'h0, ovf, cout}, 16'h0000);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        chk("vec4_sum", {8'h0, sum}, 16'h007F);
        chk("vec4_flags", {14'h0, ovf, cout}, 16'h0003);

        // Start during RUN is ignored
        e1 = model(8'h12, 8'h34, 1'b0);
        a = 8'h12;
        b = 8'h34;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        d0 = done_cnt;
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign");
        check_result("ign", e1);
        tick();
        tick();
        chk("ign_one_done", 16'(done_cnt - d0), 16'h1);
        chk("ign_idle", {15'h0, busy}, 16'h0);
        prev_sum = e1[WIDTH-1:0];

        // Asynchronous reset mid-RUN
        a = 8'h77;
        b = 8'h11;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("arst_busy", {15'h0, busy}, 16'h0);
        chk("arst_done", {15'h0, done}, 16'h0);
        chk("arst_sum", {8'h0, sum}, 16'h0);
        chk("arst_flags", {14'h0, ovf, cout}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (WIDTH + 3) tick();
        chk("arst_no_done", 16'(done_cnt - d0), 16'h0);
        prev_sum = '0;

        // Back-to-back with start held through DONE
        e1 = model(8'h3C, 8'h4D, 1'b0);
        e2 = model(8'h05, 8'hC8, 1'b1);
        a = 8'h3C;
        b = 8'h4D;
        sub = 1'b0;
        start = 1'b1;
        tick();
        wait_done("b2b1");
        t1 = cyc;
        check_result("b2b1", e1);
        a = 8'h05;
        b = 8'hC8;
        sub = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_rerun", {15'h0, busy}, 16'h1);
        wait_done("b2b2");
        t2 = cyc;
        chk("b2b_spacing", 16'(t2 - t1), 16'(WIDTH + 1));
        check_result("b2b2", e2);
        prev_sum = e2[WIDTH-1:0];
        tick();

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            run_op("rnd", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
